// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: direction encodings and the
// per-cycle operation chosen by the priority encoder.
package counter_pkg;

    localparam logic MODE_UP   = 1'b1;
    localparam logic MODE_DOWN = 1'b0;

    typedef enum logic [2:0] {
        CNT_HOLD,
        CNT_UP,
        CNT_DOWN,
        CNT_LOAD,
        CNT_CLEAR
    } cnt_op_t;

endpackage

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with modulus, wrap/saturate handling, load/clear,
// boundary decodes, a registered wrap pulse and a sticky overflow flag.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH    = 5,
    parameter int MODULUS  = 32,
    parameter bit SATURATE = 1'b0
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             ENABLE,
    input  logic             MODE,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] LOAD_VAL,
    input  logic             CLEAR,
    output logic [WIDTH-1:0] OUT,
    output logic             AT_MAX,
    output logic             AT_MIN,
    output logic             WRAP,
    output logic             OVF_STICKY
);

    // MODULUS may equal 2**WIDTH, so it is only representable in WIDTH+1 bits.
    localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);

    generate
        if ((MODULUS < 2) || (longint'(MODULUS) > (longint'(1) << WIDTH))) begin : g_bad_modulus
            $fatal(1, "updown_counter_mod: MODULUS must lie in 2..2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   inc_val;
    cnt_op_t          op;

    always_comb begin
        op = CNT_HOLD;
        if (CLEAR) begin
            op = CNT_CLEAR;
        end else if (LOAD) begin
            op = CNT_LOAD;
        end else if (ENABLE) begin
            op = (MODE == MODE_UP) ? CNT_UP : CNT_DOWN;
        end
    end

    assign inc_val = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};

    always_comb begin
        cnt_d  = cnt_q;
        wrap_d = 1'b0;
        ovf_d  = ovf_q;
        case (op)
            CNT_CLEAR: begin
                cnt_d = '0;
                ovf_d = 1'b0;
            end
            CNT_LOAD: begin
                if ({1'b0, LOAD_VAL} >= MOD_EXT) begin
                    cnt_d = MAX_VAL;
                    ovf_d = 1'b1;
                end else begin
                    cnt_d = LOAD_VAL;
                end
            end
            CNT_UP: begin
                if (inc_val == MOD_EXT) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = '0;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = inc_val[WIDTH-1:0];
                end
            end
            CNT_DOWN: begin
                if (cnt_q == '0) begin
                    ovf_d = 1'b1;
                    if (!SATURATE) begin
                        cnt_d  = MAX_VAL;
                        wrap_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_q  <= '0;
            wrap_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            wrap_q <= wrap_d;
            ovf_q  <= ovf_d;
        end
    end

    assign OUT        = cnt_q;
    assign AT_MAX     = (cnt_q == MAX_VAL);
    assign AT_MIN     = (cnt_q == '0);
    assign WRAP       = wrap_q;
    assign OVF_STICKY = ovf_q;

endmodule

// File: tb/tb_updown_counter_mod.sv
// Directed bench: three counter instances (5b/32 wrap, 4b/10 wrap, 4b/10 saturate)
// sharing stimulus, with only the selected instance receiving enable/load/clear.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst, en, mode, ld, clr;
    logic [4:0] ld_val;
    int         sel;
    int         nchk  = 0;
    int         npass = 0;

    logic       en_a, en_b, en_c, ld_a, ld_b, ld_c, clr_a, clr_b, clr_c;
    logic [4:0] out_a;
    logic [3:0] out_b, out_c;
    logic       max_a, min_a, wrap_a, ovf_a;
    logic       max_b, min_b, wrap_b, ovf_b;
    logic       max_c, min_c, wrap_c, ovf_c;

    always #5 clk = ~clk;

    assign en_a  = en  && (sel == 0);
    assign en_b  = en  && (sel == 1);
    assign en_c  = en  && (sel == 2);
    assign ld_a  = ld  && (sel == 0);
    assign ld_b  = ld  && (sel == 1);
    assign ld_c  = ld  && (sel == 2);
    assign clr_a = clr && (sel == 0);
    assign clr_b = clr && (sel == 1);
    assign clr_c = clr && (sel == 2);

    updown_counter_mod #(.WIDTH(5), .MODULUS(32), .SATURATE(1'b0)) u_a (
        .CLK(clk), .RST(rst), .ENABLE(en_a), .MODE(mode), .LOAD(ld_a),
        .LOAD_VAL(ld_val), .CLEAR(clr_a), .OUT(out_a), .AT_MAX(max_a),
        .AT_MIN(min_a), .WRAP(wrap_a), .OVF_STICKY(ovf_a)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b0)) u_b (
        .CLK(clk), .RST(rst), .ENABLE(en_b), .MODE(mode), .LOAD(ld_b),
        .LOAD_VAL(ld_val[3:0]), .CLEAR(clr_b), .OUT(out_b), .AT_MAX(max_b),
        .AT_MIN(min_b), .WRAP(wrap_b), .OVF_STICKY(ovf_b)
    );

    updown_counter_mod #(.WIDTH(4), .MODULUS(10), .SATURATE(1'b1)) u_c (
        .CLK(clk), .RST(rst), .ENABLE(en_c), .MODE(mode), .LOAD(ld_c),
        .LOAD_VAL(ld_val[3:0]), .CLEAR(clr_c), .OUT(out_c), .AT_MAX(max_c),
        .AT_MIN(min_c), .WRAP(wrap_c), .OVF_STICKY(ovf_c)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        $display("check %-14s observed %0d expected %0d", tag, obs, exp);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; mode = 1'b1; ld = 1'b0; clr = 1'b0; ld_val = '0; sel = 0;
        tick();
        rst = 1'b0;
        chk("rst_out_a", 32'(out_a), 0);
        chk("rst_min_a", 32'(min_a), 1);
        chk("rst_max_a", 32'(max_a), 0);
        chk("rst_wrap_a", 32'(wrap_a), 0);
        chk("rst_ovf_a", 32'(ovf_a), 0);

        // Instance A: count up to the top, then wrap.
        sel = 0; en = 1'b1; mode = 1'b1;
        repeat (31) tick();
        chk("up31_out", 32'(out_a), 31);
        chk("up31_max", 32'(max_a), 1);
        chk("up31_ovf", 32'(ovf_a), 0);
        tick();
        chk("wrapup_out", 32'(out_a), 0);
        chk("wrapup_wrap", 32'(wrap_a), 1);
        chk("wrapup_ovf", 32'(ovf_a), 1);
        en = 1'b0;
        tick();
        chk("wrapup_pulse", 32'(wrap_a), 0);
        chk("ovf_sticky_a", 32'(ovf_a), 1);

        // Instance B: down-wrap with modulus 10.
        sel = 1; en = 1'b1; mode = 1'b0;
        tick();
        chk("dnwrap_out", 32'(out_b), 9);
        chk("dnwrap_wrap", 32'(wrap_b), 1);
        chk("dnwrap_max", 32'(max_b), 1);
        tick();
        chk("dn8_out", 32'(out_b), 8);
        chk("dn8_wrap", 32'(wrap_b), 0);

        // Priority: clear beats load beats enable.
        clr = 1'b1; ld = 1'b1; ld_val = 5'd7; mode = 1'b1;
        tick();
        chk("prio_clr_out", 32'(out_b), 0);
        chk("prio_clr_ovf", 32'(ovf_b), 0);
        clr = 1'b0;
        tick();
        chk("prio_ld_out", 32'(out_b), 7);
        ld_val = 5'd12;
        tick();
        chk("badld_out", 32'(out_b), 9);
        chk("badld_ovf", 32'(ovf_b), 1);
        chk("badld_max", 32'(max_b), 1);

        // Disable holds, reset mid-count wins over enable.
        ld = 1'b0; en = 1'b0; clr = 1'b1;
        tick();
        clr = 1'b0; ld = 1'b1; ld_val = 5'd5;
        tick();
        ld = 1'b0; en = 1'b0; mode = 1'b1;
        repeat (3) tick();
        chk("hold_out", 32'(out_b), 5);
        en = 1'b1; rst = 1'b1;
        tick();
        chk("midrst_out", 32'(out_b), 0);
        rst = 1'b0;
        tick();
        chk("resume_out", 32'(out_b), 1);

        // Instance C: saturate at both ends.
        en = 1'b0; sel = 2; ld = 1'b1; ld_val = 5'd9;
        tick();
        ld = 1'b0;
        chk("sat_ld_out", 32'(out_c), 9);
        chk("sat_ld_ovf", 32'(ovf_c), 0);
        en = 1'b1; mode = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("sat_up_out", 32'(out_c), 9);
            chk("sat_up_wrap", 32'(wrap_c), 0);
        end
        chk("sat_up_ovf", 32'(ovf_c), 1);
        en = 1'b0; ld = 1'b1; ld_val = 5'd0;
        tick();
        ld = 1'b0; en = 1'b1; mode = 1'b0;
        tick();
        chk("sat_dn_out", 32'(out_c), 0);
        chk("sat_dn_wrap", 32'(wrap_c), 0);
        chk("sat_dn_min", 32'(min_c), 1);
        en = 1'b0;

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
